// File: rtl/cache_mem_ctrl.sv
// Memory-side sequencer shared by the D-cache write-through path, D-cache
// refill and I-cache refill. One byte-wide RAM port; stores go out one byte
// per cycle, refills issue pipelined reads and assemble a 4-byte line.
module cache_mem_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 4,
  parameter int MEM_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_miss_addr,
  output logic              icache_rewrite_e,
  output logic [31:0]       icache_rewrite_data,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_miss_addr,
  output logic              dcache_rewrite_e,
  output logic [31:0]       dcache_rewrite_data,
  input  logic              wt_req,
  input  logic [ADDR_W-1:0] wt_addr,
  input  logic [1:0]        wt_valid_bit,
  input  logic [31:0]       wt_data,
  output logic              wt_ack,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  output logic              stall_req
);

  // A refill stays in RD until the last issued byte has come back.
  localparam int RD_CYC = LINE_BYTES + MEM_LAT;
  localparam int CW     = $clog2(RD_CYC + 4);
  localparam logic [ADDR_W-1:0] LMASK = ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, WT, RD, DONE} state_t;

  state_t            state_reg, state_next;
  logic              owner_d_reg;     // 1: refill belongs to the D-cache
  logic [ADDR_W-1:0] addr_reg;        // store address or line base
  logic [31:0]       data_reg;
  logic [2:0]        nbytes_reg;
  logic [CW-1:0]     cnt_reg;         // byte index in WT, cycle index in RD
  logic [31:0]       line_reg, line_next;
  logic [ADDR_W-1:0] a_hold_reg;
  logic [31:0]       idata_reg, ddata_reg;
  logic              take_wt, take_d, take_i;
  logic              capture;
  logic [1:0]        cap_byte;

  assign icache_rewrite_data = idata_reg;
  assign dcache_rewrite_data = ddata_reg;
  assign stall_req = rst & ((state_reg != IDLE) | wt_req | dcache_miss | icache_miss);

  // Byte i returns MEM_LAT cycles after it was issued.
  assign capture  = (state_reg == RD) && (cnt_reg >= CW'(MEM_LAT));
  assign cap_byte = 2'(cnt_reg - CW'(MEM_LAT));

  // Line register with the byte arriving this cycle merged in.
  always_comb begin
    line_next = line_reg;
    line_next[{cap_byte, 3'b000} +: 8] = mem_din;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state, arbitration and RAM/handshake outputs.
  always_comb begin
    state_next       = state_reg;
    mem_a            = a_hold_reg;
    mem_wr           = 1'b0;
    mem_dout         = 8'h00;
    wt_ack           = 1'b0;
    icache_rewrite_e = 1'b0;
    dcache_rewrite_e = 1'b0;
    take_wt          = 1'b0;
    take_d           = 1'b0;
    take_i           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rst) begin
          if (wt_req) begin
            if (wt_valid_bit != 2'b00) begin
              take_wt    = 1'b1;
              state_next = WT;
            end else begin
              wt_ack = 1'b1;   // empty store: acknowledge without touching RAM
            end
          end else if (dcache_miss) begin
            take_d     = 1'b1;
            state_next = RD;
          end else if (icache_miss) begin
            take_i     = 1'b1;
            state_next = RD;
          end
        end
      end
      WT: begin
        mem_wr   = 1'b1;
        mem_a    = addr_reg + ADDR_W'(cnt_reg);
        mem_dout = data_reg[{cnt_reg[1:0], 3'b000} +: 8];
        if (cnt_reg == CW'(nbytes_reg - 3'd1)) begin
          wt_ack     = 1'b1;
          state_next = IDLE;
        end
      end
      RD: begin
        if (cnt_reg < CW'(LINE_BYTES)) mem_a = addr_reg + ADDR_W'(cnt_reg);
        if (cnt_reg == CW'(RD_CYC - 1)) state_next = DONE;
      end
      DONE: begin
        icache_rewrite_e = ~owner_d_reg;
        dcache_rewrite_e = owner_d_reg;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latching, counters, line assembly and per-side line holding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_d_reg <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
      nbytes_reg  <= '0;
      cnt_reg     <= '0;
      line_reg    <= '0;
      a_hold_reg  <= '0;
      idata_reg   <= '0;
      ddata_reg   <= '0;
    end else begin
      a_hold_reg <= mem_a;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (take_wt) begin
            addr_reg <= wt_addr;
            data_reg <= wt_data;
            case (wt_valid_bit)
              2'b01:   nbytes_reg <= 3'd1;
              2'b10:   nbytes_reg <= 3'd2;
              default: nbytes_reg <= 3'd4;
            endcase
          end else if (take_d) begin
            addr_reg    <= dcache_miss_addr & ~LMASK;
            owner_d_reg <= 1'b1;
          end else if (take_i) begin
            addr_reg    <= icache_miss_addr & ~LMASK;
            owner_d_reg <= 1'b0;
          end
        end
        WT: cnt_reg <= cnt_reg + 1'b1;
        RD: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (capture) line_reg <= line_next;
          if (state_next == DONE) begin
            if (owner_d_reg) ddata_reg <= line_next;
            else             idata_reg <= line_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
